// File: rtl/openofdm_rx_event_watchdog_pkg.sv
// Shared event indices, reset FSM encoding and helpers for the RX event watchdog.
// Imported by the watchdog top and its counter sub-module.
package openofdm_rx_event_watchdog_pkg;

   localparam int EVT_LEN_SHORT = 0;
   localparam int EVT_LEN_LONG  = 1;
   localparam int EVT_PHASE     = 2;
   localparam int EVT_SMALL_EQ  = 3;
   localparam int EVT_STUCK     = 4;
   localparam int EVT_EXT0      = 5;
   localparam int NUM_INT_EVT   = 5;

   typedef enum logic [1:0] {
      WD_IDLE    = 2'd0,
      WD_RST     = 2'd1,
      WD_HOLDOFF = 2'd2
   } wd_state_t;

   // 17-bit magnitude so that -32768 maps to 32768 without overflow
   function automatic logic [16:0] abs17(input logic [15:0] v);
      logic [16:0] x;
      x = {v[15], v};
      abs17 = x[16] ? (~x + 17'd1) : x;
   endfunction

endpackage

// File: rtl/openofdm_rx_event_watchdog_counter.sv
// One saturating event counter; a clear in the same cycle as an
// increment wins and leaves the counter at zero.
module openofdm_rx_event_watchdog_counter #(
   parameter int CNT_W = 22
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   // saturating count with clear priority
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/openofdm_rx_event_watchdog.sv
// RX event watchdog: per-event saturating counters and a timed receiver reset
// with hold-off. Define OPENOFDM_RX_WD_CAUSE_EN to build the last_cause capture.
module openofdm_rx_event_watchdog
   import openofdm_rx_event_watchdog_pkg::*;
#(
   parameter int NUM_EXT_EVT = 3,
   parameter int CNT_W       = 22,
   parameter int LEN_W       = 16,
   parameter int EQ_SMALL_SH = 4,
   parameter int HOLDOFF     = 64,
   localparam int NUM_EVT    = NUM_INT_EVT + NUM_EXT_EVT,
   localparam int SEL_W      = $clog2(NUM_EVT)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [4:0]             state,
   input  logic                   sig_valid,
   input  logic [LEN_W-1:0]       signal_len,
   input  logic [LEN_W-1:0]       min_len_th,
   input  logic [LEN_W-1:0]       max_len_th,
   input  logic                   long_preamble_detected,
   input  logic [15:0]            phase_offset,
   input  logic [16:0]            po_abs_th,
   input  logic [31:0]            equalizer,
   input  logic                   equalizer_valid,
   input  logic                   ofdm_symbol_eq_out_pulse,
   input  logic [5:0]             small_eq_th,
   input  logic [CNT_W-1:0]       stuck_th,
   input  logic [NUM_EXT_EVT-1:0] ext_evt,
   input  logic [NUM_EVT-1:0]     evt_en,
   input  logic [NUM_EVT-1:0]     rst_mask,
   input  logic [3:0]             rst_len,
   input  logic [SEL_W-1:0]       evt_sel,
   input  logic                   cnt_clr,
   output logic [CNT_W-1:0]       evt_count,
   output logic                   receiver_rst,
   output logic [NUM_EVT-1:0]     last_cause
);

   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int TMR_W = (HW > 4) ? HW : 4;
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF - 1);
   localparam logic [16:0] SMALL_LIM = 17'd1 << EQ_SMALL_SH;

   logic [NUM_EVT-1:0] evt_raw;
   logic [NUM_EVT-1:0] evt_pulse;

   logic [16:0] po_abs;
   logic [16:0] i_abs;
   logic [16:0] q_abs;
   logic        eq_small;

   logic [5:0]  small_cnt;
   logic [5:0]  small_base;
   logic [5:0]  small_nxt;
   logic        small_armed;
   logic        small_arm_eff;
   logic        small_hit;

   logic [4:0]       state_q;
   logic [CNT_W-1:0] stuck_run;
   logic [CNT_W-1:0] stuck_nxt;
   logic             stuck_done;
   logic             stuck_done_eff;
   logic             stuck_hit;
   logic             same;

   logic [CNT_W-1:0] cnt [NUM_EVT];

   wd_state_t        wd_state;
   wd_state_t        wd_next;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_nxt;
   logic [3:0]       rst_last;
   logic             trig;

   assign po_abs   = abs17(phase_offset);
   assign i_abs    = abs17(equalizer[31:16]);
   assign q_abs    = abs17(equalizer[15:0]);
   assign eq_small = equalizer_valid & (i_abs < SMALL_LIM) & (q_abs < SMALL_LIM);

   // small-sample count per symbol; a strobe with the boundary pulse starts the new symbol
   always_comb begin
      small_base    = ofdm_symbol_eq_out_pulse ? 6'd0 : small_cnt;
      small_nxt     = small_base;
      if (eq_small && (small_base != 6'h3f))
         small_nxt = small_base + 6'd1;
      small_arm_eff = ofdm_symbol_eq_out_pulse | small_armed;
      small_hit     = eq_small & small_arm_eff & (small_eq_th != 6'd0) &
                      (small_nxt == small_eq_th);
   end

   // small-sample counter and one-shot arm flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         small_cnt   <= '0;
         small_armed <= 1'b1;
      end else begin
         small_cnt   <= small_nxt;
         small_armed <= small_arm_eff & ~small_hit;
      end
   end

   // run length of the current non-changing state; holds once it has fired
   always_comb begin
      same           = (state == state_q);
      stuck_done_eff = same & stuck_done;
      if (!same)
         stuck_nxt = CNT_W'(1);
      else if (stuck_done || (stuck_run == {CNT_W{1'b1}}))
         stuck_nxt = stuck_run;
      else
         stuck_nxt = stuck_run + CNT_W'(1);
      stuck_hit = (state != 5'd0) & (stuck_th != '0) & ~stuck_done_eff &
                  (stuck_nxt == stuck_th);
   end

   // stuck-state timer registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= '0;
         stuck_run  <= '0;
         stuck_done <= 1'b0;
      end else begin
         state_q    <= state;
         stuck_run  <= stuck_nxt;
         stuck_done <= stuck_done_eff | stuck_hit;
      end
   end

   // raw event detection
   always_comb begin
      evt_raw = '0;
      evt_raw[EVT_LEN_SHORT] = sig_valid & enable & (signal_len < min_len_th);
      evt_raw[EVT_LEN_LONG]  = sig_valid & enable & (signal_len > max_len_th);
      evt_raw[EVT_PHASE]     = long_preamble_detected & enable & (po_abs > po_abs_th);
      evt_raw[EVT_SMALL_EQ]  = small_hit & enable;
      evt_raw[EVT_STUCK]     = stuck_hit;
      evt_raw[EVT_EXT0 +: NUM_EXT_EVT] = ext_evt;
   end

   // registered, individually enabled event pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         evt_pulse <= '0;
      else
         evt_pulse <= evt_raw & evt_en;
   end

   for (genvar g = 0; g < NUM_EVT; g++) begin : g_cnt
      openofdm_rx_event_watchdog_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clock (clock),
         .reset (reset),
         .inc   (evt_pulse[g]),
         .clr   (cnt_clr && (evt_sel == SEL_W'(g))),
         .count (cnt[g])
      );
   end

   // registered counter readout
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         evt_count <= '0;
      else if (int'(evt_sel) < NUM_EVT)
         evt_count <= cnt[evt_sel];
      else
         evt_count <= '0;
   end

   assign trig     = |(evt_pulse & rst_mask);
   assign rst_last = (rst_len == 4'd0) ? 4'd0 : (rst_len - 4'd1);

   // reset FSM state and timer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_state <= WD_IDLE;
         tmr      <= '0;
      end else begin
         wd_state <= wd_next;
         tmr      <= tmr_nxt;
      end
   end

   // reset FSM next state: pulse then hold-off, never retriggered mid-sequence
   always_comb begin
      wd_next = wd_state;
      tmr_nxt = tmr;
      unique case (wd_state)
         WD_IDLE: begin
            if (trig) begin
               wd_next = WD_RST;
               tmr_nxt = '0;
            end
         end
         WD_RST: begin
            if (tmr == TMR_W'(rst_last)) begin
               wd_next = WD_HOLDOFF;
               tmr_nxt = '0;
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         WD_HOLDOFF: begin
            if (tmr == HOLD_LAST) begin
               wd_next = WD_IDLE;
               tmr_nxt = '0;
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         default: begin
            wd_next = WD_IDLE;
            tmr_nxt = '0;
         end
      endcase
   end

   assign receiver_rst = (wd_state == WD_RST);

`ifdef OPENOFDM_RX_WD_CAUSE_EN
   // capture the triggering events when a reset pulse starts
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         last_cause <= '0;
      else if ((wd_state == WD_IDLE) && trig)
         last_cause <= evt_pulse & rst_mask;
   end
`else
   assign last_cause = '0;
`endif

endmodule
